// File: rtl/mcu_addr_engine_if.sv
// rtl/mcu_addr_engine_if.sv - memory arbiter request/ready bus of the address engine
// Purpose: groups the arbiter handshake and data signals.
// Signals:
//   mem_rq_rdy   arbiter ready (rising edge completes a request)
//   mem_data_in  read data from the arbiter
//   mem_rrq      one-cycle read request
//   mem_wrq      one-cycle write request
//   mem_addr     address of the active channel
//   mem_data_out write data
//   busy         a request is outstanding
interface mcu_addr_engine_if #(
    parameter int ADDR_W = 24
);
    logic              mem_rq_rdy;
    logic [7:0]        mem_data_in;
    logic              mem_rrq;
    logic              mem_wrq;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data_out;
    logic              busy;

    modport master (
        input  mem_rq_rdy, mem_data_in,
        output mem_rrq, mem_wrq, mem_addr, mem_data_out, busy
    );

    modport slave (
        output mem_rq_rdy, mem_data_in,
        input  mem_rrq, mem_wrq, mem_addr, mem_data_out, busy
    );
endinterface

// File: rtl/mcu_addr_engine.sv
// rtl/mcu_addr_engine.sv - multi-channel MCU/DMA memory address pointer engine
// Purpose: N_CH address pointers with per-channel stride and wrap mask, MCU
//          read/write streams over a single-outstanding arbiter handshake,
//          and DMA increment pulses.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_cmd_ready       command byte strobe (byte 1)
//   i_param_ready     parameter byte strobe (byte >= 2)
//   i_cmd_data        command byte, stable for the transfer
//   i_param_data      parameter byte
//   i_spi_byte_cnt    byte index in the transfer
//   i_dma_nextaddr    DMA advance pulse for channel i_dma_ch
//   i_dma_ch          DMA channel
//   o_spi_data_out    byte returned to the MCU
//   o_ch_addr_flat    all pointers, channel c at [c*ADDR_W +: ADDR_W]
//   mem               arbiter bus (master side)
module mcu_addr_engine #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cmd_ready,
    input  logic                   i_param_ready,
    input  logic [7:0]             i_cmd_data,
    input  logic [7:0]             i_param_data,
    input  logic [31:0]            i_spi_byte_cnt,
    input  logic                   i_dma_nextaddr,
    input  logic [3:0]             i_dma_ch,
    output logic [7:0]             o_spi_data_out,
    output logic [N_CH*ADDR_W-1:0] o_ch_addr_flat,
    mcu_addr_engine_if.master      mem
);
    localparam int NB = ADDR_W / 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;

    localparam logic [3:0] OP_ADDR   = 4'h0;
    localparam logic [3:0] OP_MASK   = 4'h1;
    localparam logic [3:0] OP_STRIDE = 4'h2;
    localparam logic [3:0] OP_READ   = 4'h8;
    localparam logic [3:0] OP_WRITE  = 4'h9;

    logic [ADDR_W-1:0] r_ptr    [N_CH];
    logic [ADDR_W-1:0] r_mask   [N_CH];
    logic [7:0]        r_stride [N_CH];
    logic [1:0]        r_state;
    logic [3:0]        r_act_ch;
    logic              r_overrun;
    logic              r_rrq;
    logic              r_wrq;
    logic [7:0]        r_data_out;
    logic [7:0]        r_spi_out;
    logic              r_rdy_d1;
    logic              r_rdy_d2;

    logic [3:0]        w_op;
    logic [3:0]        w_c;
    logic              w_ch_cmd;
    logic              w_idle;
    logic              w_rd_trig;
    logic              w_wr_trig;
    logic              w_edge;
    logic              w_ld_byte;
    logic [N_CH-1:0]   w_sel;
    logic [1:0]        w_k [N_CH];
    logic [ADDR_W-1:0] w_addr;

    // Advance by k strides; bits outside the mask are frozen so the pointer
    // stays inside its ring window.
    function automatic logic [ADDR_W-1:0] f_adv(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] m,
                                                input logic [7:0]        s,
                                                input logic [1:0]        k);
        logic [ADDR_W-1:0] sum;
        sum = a + ADDR_W'(s) * ADDR_W'(k);
        return (a & ~m) | (sum & m);
    endfunction

    // MSB-first byte load; byte 2 lands in the top byte and clears the rest.
    function automatic logic [ADDR_W-1:0] f_load(input logic [ADDR_W-1:0] old,
                                                 input logic [7:0]        b,
                                                 input logic [31:0]       cnt);
        logic [ADDR_W-1:0] r;
        r = (cnt == 32'd2) ? '0 : old;
        for (int j = 0; j < NB; j++) begin
            if (cnt == 32'(NB + 1 - j)) r[j*8 +: 8] = b;
        end
        return r;
    endfunction

    // 0xFx are global commands; the low nibble is not a channel for them.
    assign w_op      = i_cmd_data[7:4];
    assign w_c       = i_cmd_data[3:0];
    assign w_ch_cmd  = (32'(w_c) < N_CH) && (w_op != 4'hF);
    assign w_idle    = (r_state == S_IDLE);
    assign w_rd_trig = w_ch_cmd && (w_op == OP_READ) && (i_cmd_ready || i_param_ready);
    assign w_wr_trig = w_ch_cmd && (w_op == OP_WRITE) && i_param_ready &&
                       (i_spi_byte_cnt >= 32'd2);
    // Edge qualified by state so a late ready after reset is ignored.
    assign w_edge    = r_rdy_d1 && !r_rdy_d2 && !w_idle;
    assign w_ld_byte = i_param_ready && (i_spi_byte_cnt >= 32'd2) &&
                       (i_spi_byte_cnt <= 32'(NB + 1));

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sel[i] = w_ch_cmd && (32'(w_c) == i);
            w_k[i]   = {1'b0, i_dma_nextaddr && (32'(i_dma_ch) == i)} +
                       {1'b0, w_edge && (r_act_ch == 4'(i))};
            if (r_act_ch == 4'(i)) w_addr = r_ptr[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!rst_n) begin
                r_ptr[i]    <= '0;
                r_mask[i]   <= '1;
                r_stride[i] <= 8'd1;
            end else begin
                // A load discards any advance in the same cycle.
                if (w_sel[i] && w_ld_byte && (w_op == OP_ADDR))
                    r_ptr[i] <= f_load(r_ptr[i], i_param_data, i_spi_byte_cnt);
                else if (w_k[i] != 2'd0)
                    r_ptr[i] <= f_adv(r_ptr[i], r_mask[i], r_stride[i], w_k[i]);
                if (w_sel[i] && w_ld_byte && (w_op == OP_MASK))
                    r_mask[i] <= f_load(r_mask[i], i_param_data, i_spi_byte_cnt);
                if (w_sel[i] && i_param_ready && (i_spi_byte_cnt == 32'd2) &&
                    (w_op == OP_STRIDE))
                    r_stride[i] <= i_param_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_act_ch   <= 4'd0;
            r_overrun  <= 1'b0;
            r_rrq      <= 1'b0;
            r_wrq      <= 1'b0;
            r_data_out <= 8'd0;
            r_spi_out  <= 8'd0;
            r_rdy_d1   <= 1'b0;
            r_rdy_d2   <= 1'b0;
        end else begin
            r_rdy_d1 <= mem.mem_rq_rdy;
            r_rdy_d2 <= r_rdy_d1;
            r_rrq    <= 1'b0;
            r_wrq    <= 1'b0;
            if (w_ch_cmd && i_cmd_ready && ((w_op == OP_READ) || (w_op == OP_WRITE)))
                r_act_ch <= w_c;
            if (w_rd_trig || w_wr_trig) begin
                if (w_idle) begin
                    r_act_ch <= w_c;
                    if (w_rd_trig) begin
                        r_rrq   <= 1'b1;
                        r_state <= S_RD_WAIT;
                    end else begin
                        r_wrq      <= 1'b1;
                        r_data_out <= i_param_data;
                        r_state    <= S_WR_WAIT;
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_edge) begin
                r_state <= S_IDLE;
                if (r_state == S_RD_WAIT) r_spi_out <= mem.mem_data_in;
            end
            if ((i_cmd_data == 8'hF1) && (i_cmd_ready || i_param_ready))
                r_spi_out <= {r_overrun, !w_idle, 6'b0};
            if ((i_cmd_data == 8'hF6) && i_cmd_ready)
                r_overrun <= 1'b0;
        end
    end

    assign mem.mem_rrq      = r_rrq;
    assign mem.mem_wrq      = r_wrq;
    assign mem.mem_addr     = w_addr;
    assign mem.mem_data_out = r_data_out;
    assign mem.busy         = !w_idle;
    assign o_spi_data_out   = r_spi_out;

    always_comb begin
        o_ch_addr_flat = '0;
        for (int i = 0; i < N_CH; i++) o_ch_addr_flat[i*ADDR_W +: ADDR_W] = r_ptr[i];
    end
endmodule
